// File: rtl/tmr_vote_pkg.sv
// -----------------------------------------------------------------------------
// tmr_vote_pkg
// Shared types and helpers for the TMR majority voter / scrub controller.
//   state_e   : scrub FSM states (IDLE, HOLD, REQ)
//   DOM_*     : fault-domain encodings driven on scrub_dom
//   sat_inc() : saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package tmr_vote_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        REQ  = 2'd2
    } state_e;

    localparam logic [1:0] DOM_A     = 2'd0;
    localparam logic [1:0] DOM_B     = 2'd1;
    localparam logic [1:0] DOM_C     = 2'd2;
    localparam logic [1:0] DOM_MULTI = 2'd3;

    // Increment val, sticking at the all-ones value of a `width`-bit counter.
    // The caller zero-extends its counter into val and truncates the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/tmr_majority.sv
// -----------------------------------------------------------------------------
// tmr_majority
// Purely combinational bitwise 2-of-3 vote over three replicas of a bus, plus
// a per-replica "disagrees with the vote" flag.
// Ports:
//   d_a, d_b, d_c : in  [WIDTH]  replicas A/B/C
//   maj           : out [WIDTH]  bitwise majority
//   mis_a/b/c     : out          replica differs from maj in at least one bit
// -----------------------------------------------------------------------------
module tmr_majority #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic [WIDTH-1:0] d_c,
    output logic [WIDTH-1:0] maj,
    output logic             mis_a,
    output logic             mis_b,
    output logic             mis_c
);

    assign maj   = (d_a & d_b) | (d_a & d_c) | (d_b & d_c);
    assign mis_a = |(d_a ^ maj);
    assign mis_b = |(d_b ^ maj);
    assign mis_c = |(d_c ^ maj);

endmodule

// File: rtl/tmr_vote_scrub.sv
// -----------------------------------------------------------------------------
// tmr_vote_scrub
// Receive-side voter for a triplicated bus. Registers the majority vote,
// flags disagreement, keeps a saturating fault counter per domain and, when
// one domain is faulty for HOLDOFF consecutive valid samples, raises a level
// scrub request for that domain until acknowledged.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   d_a, d_b, d_c       : in  [WIDTH] replicas A/B/C
//   valid_in            : in  sample strobe
//   q                   : out [WIDTH] registered vote (holds when no sample)
//   valid_out           : out valid_in delayed one cycle
//   err_any             : out registered "sample had a mismatch"
//   err_cnt_a/b/c       : out [CNT_W] saturating per-domain fault counts
//   cnt_clr             : in  clear all counters (wins over increment)
//   scrub_req           : out level request, held until scrub_ack
//   scrub_dom           : out [2] 0=A 1=B 2=C 3=multi; 0 when no request
//   scrub_ack           : in  scrub done; ignored outside REQ
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module tmr_vote_scrub
    import tmr_vote_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 4    // 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic [WIDTH-1:0] d_c,
    input  logic             valid_in,
    output logic [WIDTH-1:0] q,
    output logic             valid_out,
    output logic             err_any,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c,
    input  logic             cnt_clr,
    output logic             scrub_req,
    output logic [1:0]       scrub_dom,
    input  logic             scrub_ack
);

    localparam logic [7:0] HOLDOFF_C = 8'(HOLDOFF);

    // ------------------------------------------------------------------
    // Vote and attribution
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] maj;
    logic             mis_a, mis_b, mis_c, mis_any;
    logic [1:0]       dom;

    tmr_majority #(.WIDTH(WIDTH)) u_majority (
        .d_a   (d_a),
        .d_b   (d_b),
        .d_c   (d_c),
        .maj   (maj),
        .mis_a (mis_a),
        .mis_b (mis_b),
        .mis_c (mis_c)
    );

    assign mis_any = mis_a | mis_b | mis_c;

    // A single disagreeing replica is the culprit; with two or three
    // disagreeing there is no trustworthy attribution.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dom = DOM_MULTI;
        case ({mis_a, mis_b, mis_c})
            3'b100:  dom = DOM_A;
            3'b010:  dom = DOM_B;
            3'b001:  dom = DOM_C;
            default: dom = DOM_MULTI;
        endcase
    end

    // ------------------------------------------------------------------
    // Data path registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q;
    logic             err_any_q;

    assign q_d = valid_in ? maj : q_q;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= '0;
            valid_q   <= 1'b0;
            err_any_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            valid_q   <= valid_in;
            err_any_q <= valid_in & mis_any;
        end
    end

    assign q         = q_q;
    assign valid_out = valid_q;
    assign err_any   = err_any_q;

    // ------------------------------------------------------------------
    // Per-domain saturating fault counters (independent of the FSM)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_c_q;
    logic [CNT_W-1:0] cnt_a_d, cnt_b_d, cnt_c_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        cnt_c_d = cnt_c_q;
        if (cnt_clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
            cnt_c_d = '0;
        end else if (valid_in) begin
            if (mis_a) cnt_a_d = CNT_W'(sat_inc(32'(cnt_a_q), CNT_W));
            if (mis_b) cnt_b_d = CNT_W'(sat_inc(32'(cnt_b_q), CNT_W));
            if (mis_c) cnt_c_d = CNT_W'(sat_inc(32'(cnt_c_q), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            cnt_c_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            cnt_c_q <= cnt_c_d;
        end
    end

    assign err_cnt_a = cnt_a_q;
    assign err_cnt_b = cnt_b_q;
    assign err_cnt_c = cnt_c_q;

    // ------------------------------------------------------------------
    // Scrub FSM
    //   hcnt counts consecutive valid faulty samples blamed on cur_dom.
    //   Invalid cycles leave HOLD untouched so gaps do not break a run.
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [1:0] cur_dom_q, cur_dom_d;
    logic [1:0] scrub_dom_q, scrub_dom_d;
    logic [7:0] hcnt_inc;

    assign hcnt_inc = hcnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        cur_dom_d = cur_dom_q;
        case (state_q)
            IDLE: begin
                if (valid_in && mis_any) begin
                    hcnt_d    = 8'd1;
                    cur_dom_d = dom;
                    state_d   = (HOLDOFF_C == 8'd1) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (valid_in) begin
                    if (!mis_any) begin
                        hcnt_d  = 8'd0;
                        state_d = IDLE;
                    end else if (dom == cur_dom_q) begin
                        hcnt_d = hcnt_inc;
                        if (hcnt_inc >= HOLDOFF_C) state_d = REQ;
                    end else begin
                        // Blame moved to another domain: start a new run.
                        hcnt_d    = 8'd1;
                        cur_dom_d = dom;
                    end
                end
            end
            REQ: begin
                // cur_dom is frozen here so scrub_dom stays stable.
                if (scrub_ack) begin
                    hcnt_d  = 8'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                hcnt_d  = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // scrub_dom only carries meaning while requesting; park it at 0 otherwise.
    assign scrub_dom_d = (state_d == REQ) ? cur_dom_d : DOM_A;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hcnt_q      <= 8'd0;
            cur_dom_q   <= DOM_A;
            scrub_dom_q <= DOM_A;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            cur_dom_q   <= cur_dom_d;
            scrub_dom_q <= scrub_dom_d;
        end
    end

    assign scrub_req = (state_q == REQ);
    assign scrub_dom = scrub_dom_q;

endmodule

// File: tb/tb_tmr_vote_scrub.sv
// -----------------------------------------------------------------------------
// tb_tmr_vote_scrub
// Directed scoreboard bench for tmr_vote_scrub (WIDTH=3, CNT_W=2, HOLDOFF=4).
// Each step drives one cycle of inputs on the falling edge and queues the
// hand-computed outputs expected after the following rising edge; a monitor
// pops and compares one entry per rising edge.
// -----------------------------------------------------------------------------
module tb_tmr_vote_scrub;

    localparam int WIDTH   = 3;
    localparam int CNT_W   = 2;
    localparam int HOLDOFF = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d_a, d_b, d_c;
    logic             valid_in;
    logic [WIDTH-1:0] q;
    logic             valid_out;
    logic             err_any;
    logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;
    logic             cnt_clr;
    logic             scrub_req;
    logic [1:0]       scrub_dom;
    logic             scrub_ack;

    tmr_vote_scrub #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_a       (d_a),
        .d_b       (d_b),
        .d_c       (d_c),
        .valid_in  (valid_in),
        .q         (q),
        .valid_out (valid_out),
        .err_any   (err_any),
        .err_cnt_a (err_cnt_a),
        .err_cnt_b (err_cnt_b),
        .err_cnt_c (err_cnt_c),
        .cnt_clr   (cnt_clr),
        .scrub_req (scrub_req),
        .scrub_dom (scrub_dom),
        .scrub_ack (scrub_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] q;
        logic             vo;
        logic             ea;
        logic [CNT_W-1:0] ca, cb, cc;
        logic             req;
        logic [1:0]       dom;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One cycle of stimulus plus the outputs expected after the next rising edge.
    task automatic step(
        input logic [2:0] da, db, dc,
        input logic v, clr, ack, r,
        input logic [2:0] eq, input logic evo, eea,
        input logic [1:0] eca, ecb, ecc,
        input logic ereq, input logic [1:0] edom);
        exp_t e;
        @(negedge clk);
        d_a = da; d_b = db; d_c = dc;
        valid_in = v; cnt_clr = clr; scrub_ack = ack; rst = r;
        step_id++;
        e.id = step_id; e.q = eq; e.vo = evo; e.ea = eea;
        e.ca = eca; e.cb = ecb; e.cc = ecc; e.req = ereq; e.dom = edom;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per rising edge that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("s%0d q", e.id),         32'(q),         32'(e.q));
                check($sformatf("s%0d valid_out", e.id), 32'(valid_out), 32'(e.vo));
                check($sformatf("s%0d err_any", e.id),   32'(err_any),   32'(e.ea));
                check($sformatf("s%0d err_cnt_a", e.id), 32'(err_cnt_a), 32'(e.ca));
                check($sformatf("s%0d err_cnt_b", e.id), 32'(err_cnt_b), 32'(e.cb));
                check($sformatf("s%0d err_cnt_c", e.id), 32'(err_cnt_c), 32'(e.cc));
                check($sformatf("s%0d scrub_req", e.id), 32'(scrub_req), 32'(e.req));
                check($sformatf("s%0d scrub_dom", e.id), 32'(scrub_dom), 32'(e.dom));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; d_a = '0; d_b = '0; d_c = '0;
        valid_in = 1'b0; cnt_clr = 1'b0; scrub_ack = 1'b0;

        //    da  db  dc   v clr ack rst    q  vo ea   ca cb cc  req dom
        // Reset, including reset winning over a valid sample.
        step(0, 0, 0,   0, 0, 0, 1,     0, 0, 0,   0, 0, 0,  0, 0);
        step(1, 5, 5,   1, 0, 0, 1,     0, 0, 0,   0, 0, 0,  0, 0);
        // Clean samples; ack outside REQ ignored; q holds on invalid cycle.
        step(5, 5, 5,   1, 0, 0, 0,     5, 1, 0,   0, 0, 0,  0, 0);
        step(5, 5, 5,   1, 0, 1, 0,     5, 1, 0,   0, 0, 0,  0, 0);
        step(2, 2, 2,   0, 0, 0, 0,     5, 0, 0,   0, 0, 0,  0, 0);
        // Single upset on A, then clean breaks the run; three more A faults
        // start a fresh run that stays short of HOLDOFF. Counter A saturates.
        step(1, 5, 5,   1, 0, 0, 0,     5, 1, 1,   1, 0, 0,  0, 0);
        step(5, 5, 5,   1, 0, 0, 0,     5, 1, 0,   1, 0, 0,  0, 0);
        step(1, 5, 5,   1, 0, 0, 0,     5, 1, 1,   2, 0, 0,  0, 0);
        step(1, 5, 5,   1, 0, 0, 0,     5, 1, 1,   3, 0, 0,  0, 0);
        step(1, 5, 5,   1, 0, 0, 0,     5, 1, 1,   3, 0, 0,  0, 0);
        step(5, 5, 5,   1, 0, 0, 0,     5, 1, 0,   3, 0, 0,  0, 0);
        step(5, 5, 5,   0, 1, 0, 0,     5, 0, 0,   0, 0, 0,  0, 0);
        // Persistent B fault with a gap; request after the 4th sample.
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   0, 1, 0,  0, 0);
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   0, 2, 0,  0, 0);
        step(0, 0, 0,   0, 0, 0, 0,     5, 0, 0,   0, 2, 0,  0, 0);
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   0, 3, 0,  0, 0);
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   0, 3, 0,  1, 1);
        // Ten cycles without ack: eight idle, two C-faulty samples.
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 0, 0, 0, 0,   5, 0, 0,   0, 3, 0,  1, 1);
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 3, 1,  1, 1);
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 3, 2,  1, 1);
        step(0, 0, 0,   0, 0, 1, 0,     5, 0, 0,   0, 3, 2,  0, 0);
        step(0, 0, 0,   0, 1, 0, 0,     5, 0, 0,   0, 0, 0,  0, 0);
        // Unattributable: 000/011/101 -> vote 001, every domain blamed.
        step(0, 3, 5,   1, 0, 0, 0,     1, 1, 1,   1, 1, 1,  0, 0);
        step(0, 3, 5,   1, 0, 0, 0,     1, 1, 1,   2, 2, 2,  0, 0);
        step(0, 3, 5,   1, 0, 0, 0,     1, 1, 1,   3, 3, 3,  0, 0);
        step(0, 3, 5,   1, 0, 0, 0,     1, 1, 1,   3, 3, 3,  1, 3);
        step(0, 0, 0,   0, 1, 1, 0,     1, 0, 0,   0, 0, 0,  0, 0);
        // Blame moves A -> B mid-run: the run restarts at the switch.
        step(1, 5, 5,   1, 0, 0, 0,     5, 1, 1,   1, 0, 0,  0, 0);
        step(1, 5, 5,   1, 0, 0, 0,     5, 1, 1,   2, 0, 0,  0, 0);
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   2, 1, 0,  0, 0);
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   2, 2, 0,  0, 0);
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   2, 3, 0,  0, 0);
        step(5, 7, 5,   1, 0, 0, 0,     5, 1, 1,   2, 3, 0,  1, 1);
        step(0, 0, 0,   0, 0, 1, 0,     5, 0, 0,   2, 3, 0,  0, 0);
        step(0, 0, 0,   0, 1, 0, 0,     5, 0, 0,   0, 0, 0,  0, 0);
        // C saturation, request for C, clear beating a same-cycle increment.
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 0, 1,  0, 0);
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 0, 2,  0, 0);
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 0, 3,  0, 0);
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 0, 3,  1, 2);
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 0, 3,  1, 2);
        step(5, 5, 4,   1, 1, 0, 0,     5, 1, 1,   0, 0, 0,  1, 2);
        step(5, 5, 4,   1, 0, 0, 0,     5, 1, 1,   0, 0, 1,  1, 2);
        // Reset while requesting, with an ack in the same cycle.
        step(5, 5, 4,   1, 0, 1, 1,     0, 0, 0,   0, 0, 0,  0, 0);
        step(5, 5, 5,   1, 0, 0, 0,     5, 1, 0,   0, 0, 0,  0, 0);
        step(0, 0, 0,   0, 0, 0, 0,     5, 0, 0,   0, 0, 0,  0, 0);
        step(0, 0, 0,   0, 0, 1, 0,     5, 0, 0,   0, 0, 0,  0, 0);

        @(negedge clk);
        scrub_ack = 1'b0;
        @(posedge clk);
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_vote_scrub.md
Name: tmr_vote_scrub

Overview:
- Receive-side companion to the triplicated datapaths that tmrg generates.
- Takes the three replicas (A/B/C) of a WIDTH-bit bus and produces a registered, bitwise-majority-voted result.
- Flags per-domain disagreement and keeps saturating error counters per domain.
- When one domain disagrees persistently, requests a scrub (refresh) of that domain through a req/ack handshake.

Parameters:
- WIDTH, 3, width of each replica bus.
- CNT_W, 8, width of each per-domain saturating error counter.
- HOLDOFF, 4, number of consecutive faulty samples attributed to the same domain before scrub_req is raised; legal range 1..255.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- d_a  in  WIDTH  replica A.
- d_b  in  WIDTH  replica B.
- d_c  in  WIDTH  replica C.
- valid_in  in  1  sample strobe; replicas are evaluated only when high.
- q  out  WIDTH  registered majority vote.
- valid_out  out  1  valid_in delayed by one cycle.
- err_any  out  1  registered: the sample had at least one mismatching domain.
- err_cnt_a  out  CNT_W  saturating fault count for domain A.
- err_cnt_b  out  CNT_W  saturating fault count for domain B.
- err_cnt_c  out  CNT_W  saturating fault count for domain C.
- cnt_clr  in  1  synchronous clear of all three counters.
- scrub_req  out  1  scrub request, level.
- scrub_dom  out  2  domain to scrub: 0=A, 1=B, 2=C, 3=multi/unattributable.
- scrub_ack  in  1  scrub completed.

Behaviour:
- Reset: one clock, synchronous active-high reset on rst. While rst is high at a clock edge, the next state is:
  - q=0, valid_out=0, err_any=0;
  - all counters 0;
  - scrub_req=0, scrub_dom=0;
  - FSM in IDLE, holdoff counter 0.
- Reset mid-handshake drops scrub_req the cycle after the rst edge; a pending ack is ignored.
- Vote: maj = (d_a&d_b)|(d_a&d_c)|(d_b&d_c), bitwise.
- Mismatch flags:
  - mis_x = |(d_x ^ maj), for x in a/b/c.
  - Attribution: exactly one flag set -> dom = that domain; two or three set -> dom = 3.
- Latency 1 cycle on valid_in:
  - q <= maj; valid_out <= valid_in; err_any <= valid_in & (mis_a|mis_b|mis_c).
  - When valid_in=0, q holds its value, valid_out=0 and err_any=0.
- Counters:
  - On valid_in & mis_x, err_cnt_x increments and saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
  - Counters run in every FSM state.
- FSM states: IDLE, HOLD, REQ.
  - IDLE, on valid_in & any mismatch: go to HOLD, hcnt=1, cur_dom=dom. If HOLDOFF=1, go directly to REQ instead.
  - HOLD, on valid_in with no mismatch: go to IDLE, hcnt=0.
  - HOLD, on valid_in & mismatch & dom==cur_dom: hcnt++. When hcnt reaches HOLDOFF, go to REQ.
  - HOLD, on valid_in & mismatch & dom!=cur_dom: restart with hcnt=1, cur_dom=dom.
  - HOLD, on valid_in=0: hold state (gaps do not break persistence).
  - REQ: scrub_req=1 and scrub_dom=cur_dom, both registered. They rise the cycle after the sample that completes HOLDOFF and stay stable until scrub_ack.
  - REQ, on scrub_ack: go to IDLE; scrub_req falls the next cycle. Samples arriving during REQ do not change scrub_dom.
- scrub_ack outside REQ is ignored.
- No combinational path from any input to any output.

Decomposition:
- Package tmr_vote_pkg holds:
  - state enum (IDLE/HOLD/REQ);
  - domain constants DOM_A=0, DOM_B=1, DOM_C=2, DOM_MULTI=3;
  - a saturating-increment function.
- Sub-module tmr_majority: combinational, parameter WIDTH. Inputs d_a/d_b/d_c; outputs maj, mis_a, mis_b, mis_c.
- Top tmr_vote_scrub owns the registers, counters and FSM.

Test Plan:
- WIDTH=3, HOLDOFF=4, clean sample: d_a=d_b=d_c=3'b101, valid_in=1 -> next cycle q=101, valid_out=1, err_any=0, counters stay 0, scrub_req=0.
- Single upset: d_a=001, d_b=d_c=101, one valid sample -> q=101, err_any=1, err_cnt_a=1, FSM in HOLD. A clean sample next -> IDLE, and scrub_req never asserts.
- Persistent fault on B: d_b=111, others 101, four valid samples with one valid_in=0 gap mid-sequence -> scrub_req=1 and scrub_dom=1 the cycle after the 4th sample. Both hold through 10 cycles without ack; pulse scrub_ack -> scrub_req=0 next cycle.
- Unattributable: d_a=000, d_b=011, d_c=101 -> q=001, all three mis flags set, all counters +1. Four such samples -> scrub_dom=3.
- Saturation/clear with CNT_W=2: five faulty samples on C -> err_cnt_c=3. cnt_clr together with a faulty sample -> err_cnt_c=0.
- Reset in REQ: assert rst while scrub_req=1 -> next cycle scrub_req=0, q=0, counters 0. A clean sample afterwards keeps FSM in IDLE.
